// File: rtl/wait_state_memory.sv
// Word-addressed single-port memory with per-access-type wait states and
// optional strict out-of-range faulting. Port vectors use big-endian bit numbering.
module wait_state_memory #(
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_WAIT  = 0,
    parameter int WRITE_WAIT = 0,
    parameter bit STRICT     = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req,
    input  logic [0:3]   write_en,
    input  logic [15:31] address,
    input  logic [0:31]  data_in,
    output logic [0:31]  data_out,
    output logic         ready,
    output logic         busy,
    output logic         fault
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [3:0]  we_q;     // bit 3 enables lane 0 (most significant byte)
    logic [16:0] addr_q;
    logic [31:0] wdata_q;

    // Zero-filled at time zero; a test bench may overwrite entries hierarchically.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [DEPTH_LOG2-1:0] index;
    logic                  out_of_range;
    logic                  execute;
    logic                  do_write;
    logic [31:0]           merged;

    // NOTE: every signal gets a default before any conditional assignment, so no latches are inferred.
    always_comb begin
        index        = addr_q[DEPTH_LOG2-1:0];
        out_of_range = (addr_q >> DEPTH_LOG2) != '0;
        execute      = (state == WAIT) && (count == '0);
        do_write     = execute && (we_q != '0) && !(STRICT && out_of_range);
        merged       = mem[index];
        for (int i = 0; i < 4; i++) begin
            if (we_q[3-i]) merged[31-8*i -: 8] = wdata_q[31-8*i -: 8];
        end
    end

    // NOTE: the memory array has no reset; reset clears only control state, so contents survive it.
    always_ff @(posedge clock) begin
        if (do_write) mem[index] <= merged;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            ready <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= WAIT;
                        busy    <= 1'b1;
                        we_q    <= write_en;
                        addr_q  <= address;
                        wdata_q <= data_in;
                        count   <= (write_en == '0) ? 4'(READ_WAIT) : 4'(WRITE_WAIT);
                    end
                end
                WAIT: begin
                    if (count != '0) begin
                        count <= count - 4'd1;
                    end else begin
                        state <= DONE;
                        ready <= 1'b1;
                        // A write returns the word as it was before this edge updates it.
                        if (STRICT && out_of_range) begin
                            data_out <= '0;
                            fault    <= 1'b1;
                        end else begin
                            data_out <= mem[index];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
